// File: rtl/count_tracker.sv
// rtl/count_tracker.sv - step/wrap checker for three counters with a round-robin event FIFO
// Optional feature: define COUNT_TRACKER_WRAP_EVENT_EN to also emit kind 1 (wrap) events.
module count_tracker #(
  parameter int WIDTH      = 8,
  parameter int WRAP_CNT_W = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [WIDTH-1:0]      count0,
  input  logic [WIDTH-1:0]      count1,
  input  logic [WIDTH-1:0]      count2,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [WIDTH+3:0]      evt_data,
  output logic [WRAP_CNT_W-1:0] wrap_cnt0,
  output logic [WRAP_CNT_W-1:0] wrap_cnt1,
  output logic [WRAP_CNT_W-1:0] wrap_cnt2,
  output logic                  err_any,
  output logic [7:0]            drop_cnt
);
  localparam int RW = WIDTH + 4;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] OCC_FULL = (AW+1)'(FIFO_DEPTH);
`ifdef COUNT_TRACKER_WRAP_EVENT_EN
  localparam bit WRAP_EVT = 1'b1;
`else
  localparam bit WRAP_EVT = 1'b0;
`endif

  typedef enum logic {UNARMED = 1'b0, TRACK = 1'b1} ch_state_t;

  ch_state_t             state_q  [3];
  ch_state_t             state_d  [3];
  logic [WIDTH-1:0]      cnt      [3];
  logic [WIDTH-1:0]      prev_q   [3];
  logic [WIDTH-1:0]      diff     [3];
  logic [WRAP_CNT_W-1:0] wrap_q   [3];
  logic [RW-1:0]         pend_d_q [3];
  logic [RW-1:0]         new_rec  [3];
  logic [2:0]            pend_v_q, step_err, wrap_hit, new_evt, grant, drop;
  logic [1:0]            rr_q, gnt_idx, drop_sum;
  logic                  push, pop;
  logic [RW-1:0]         mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_q, rd_q;
  logic [AW:0]           occ_q;
  logic [8:0]            drop_wide;

  assign cnt[0]    = count0;
  assign cnt[1]    = count1;
  assign cnt[2]    = count2;
  assign wrap_cnt0 = wrap_q[0];
  assign wrap_cnt1 = wrap_q[1];
  assign wrap_cnt2 = wrap_q[2];
  assign evt_valid = (occ_q != '0);
  assign evt_data  = evt_valid ? mem_q[rd_q] : {RW{1'b0}};

  function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] k);
    logic [2:0] j;
    j = {1'b0, base} + {1'b0, k};
    if (j >= 3'd3) j = j - 3'd3;
    return j[1:0];
  endfunction

  always_comb begin
    step_err = '0;
    wrap_hit = '0;
    new_evt  = '0;
    for (int i = 0; i < 3; i++) begin
      state_d[i]  = enable ? TRACK : UNARMED;
      diff[i]     = cnt[i] - prev_q[i];
      step_err[i] = enable && (state_q[i] == TRACK) && (diff[i] > WIDTH'(1));
      wrap_hit[i] = enable && (state_q[i] == TRACK) && (diff[i] == WIDTH'(1)) && (cnt[i] == '0);
      new_evt[i]  = step_err[i] || (WRAP_EVT && wrap_hit[i]);
      new_rec[i]  = {i[1:0], step_err[i] ? 2'd0 : 2'd1, step_err[i] ? cnt[i] : {WIDTH{1'b0}}};
    end
  end

  always_comb begin
    pop     = evt_valid && evt_ready;
    push    = 1'b0;
    gnt_idx = rr_q;
    grant   = '0;
    if ((occ_q != OCC_FULL) || pop) begin
      // Scan from farthest to nearest so the channel closest to rr_q is the last writer.
      for (int k = 2; k >= 0; k--) begin
        if (pend_v_q[rr_idx(rr_q, k[1:0])]) begin
          push    = 1'b1;
          gnt_idx = rr_idx(rr_q, k[1:0]);
        end
      end
      if (push) grant[gnt_idx] = 1'b1;
    end
    drop      = new_evt & pend_v_q & ~grant;
    drop_sum  = 2'(drop[0]) + 2'(drop[1]) + 2'(drop[2]);
    drop_wide = {1'b0, drop_cnt} + {7'b0, drop_sum};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        state_q[i]  <= UNARMED;
        prev_q[i]   <= '0;
        wrap_q[i]   <= '0;
        pend_d_q[i] <= '0;
      end
      pend_v_q <= '0;
      rr_q     <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      occ_q    <= '0;
      err_any  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        if (enable) prev_q[i] <= cnt[i];
        if (wrap_hit[i] && (wrap_q[i] != '1)) wrap_q[i] <= wrap_q[i] + 1'b1;
        // A slot freed by this cycle's grant can take the new event on the same edge.
        if (new_evt[i] && !drop[i]) begin
          pend_v_q[i] <= 1'b1;
          pend_d_q[i] <= new_rec[i];
        end else if (grant[i]) begin
          pend_v_q[i] <= 1'b0;
        end
      end
      if (|step_err) err_any <= 1'b1;
      drop_cnt <= drop_wide[8] ? 8'hff : drop_wide[7:0];
      if (push) begin
        wr_q <= wr_q + 1'b1;
        rr_q <= (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      if (push && !pop) occ_q <= occ_q + 1'b1;
      else if (!push && pop) occ_q <= occ_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= pend_d_q[gnt_idx];
  end
endmodule

// File: doc/count_tracker.md
# count_tracker

Downstream consumer of the `Top` counter block. Samples `count0`..`count2` every cycle and checks that each channel either holds or steps by exactly +1 modulo 2^WIDTH. Counts wrap-arounds per channel and reports illegal steps as event records through a small FIFO with a valid/ready handshake. Sits beside the DUT in the bench top as an always-on RTL checker whose event stream is drained by the Lua side.

## Interface
- `WIDTH`, 8, width of each monitored counter
- `WRAP_CNT_W`, 16, width of each per-channel wrap counter
- `FIFO_DEPTH`, 4, event FIFO entries (power of two, ≥2)

- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `enable`  in  1  tracking enable; low disarms all channels
- `count0`, `count1`, `count2`  in  WIDTH  monitored counter values
- `evt_valid`  out  1  FIFO head valid
- `evt_ready`  in  1  consumer accepts head
- `evt_data`  out  WIDTH+4  record {ch[1:0], kind[1:0], value[WIDTH-1:0]}; kind 0 = step error, 1 = wrap
- `wrap_cnt0`, `wrap_cnt1`, `wrap_cnt2`  out  WRAP_CNT_W  saturating wrap counts
- `err_any`  out  1  sticky: any step error since reset
- `drop_cnt`  out  8  saturating count of lost events

## Operation
- Per-channel state: UNARMED, TRACK. Reset or `enable`=0 forces UNARMED. The first edge with `enable`=1 captures `prev` and moves to TRACK with no check.
- In TRACK, each edge with `enable`=1 computes `d = count - prev` (mod 2^WIDTH), then sets `prev <= count`:
  - `d == 0`: hold, OK.
  - `d == 1`: OK. If `prev == 2^WIDTH-1` and `count == 0`, this is a wrap: `wrap_cntN` += 1, saturating at all-ones.
  - Otherwise: step error. Set `err_any`, generate event kind 0 with value = `count`.
- Each channel has a 1-deep pending register.
  - A new event while pending is full is dropped and `drop_cnt` += 1 (saturating at 255).
  - Multiple channels can drop in one cycle; `drop_cnt` adds the number of drops, saturating.
- A round-robin arbiter moves one pending event per cycle into the FIFO when the FIFO is not full, or is full with a pop in the same cycle.
  - The pointer starts at ch0 after reset and advances to the channel after the one granted.
  - A pending register cleared by a grant may be refilled on the same edge by a new event.
- FIFO: `evt_valid` = not empty. A pop occurs when `evt_valid && evt_ready`. Push and pop in the same cycle are allowed at every occupancy.
- `evt_data` is undefined-but-stable (0 after reset) when `evt_valid`=0.

## Timing
- Reset (`reset`=0 at an edge) sets:
  - all outputs to 0: `evt_valid`, `evt_data`, `wrap_cnt*`, `err_any`, `drop_cnt`;
  - FIFO empty, pending cleared, channels UNARMED, RR pointer at ch0.
- Reset asserted mid-operation discards all queued and pending events immediately.
- Latency: a violating sample at edge k loads pending at edge k. Push to the FIFO happens at edge k+1 at the earliest. `evt_valid` is high after edge k+1 (2 edges) if no contention.
- `wrap_cntN` updates at the same edge that samples the wrap.
- `enable` deassert clears nothing except arming. Pending events and the FIFO continue draining.

## Configuration
- `COUNT_TRACKER_WRAP_EVENT_EN` defined: each wrap also generates a kind 1 event, value 0, through the same pending/arbiter/FIFO path.
- Not defined: wraps only increment `wrap_cntN`. No kind 1 events are ever produced, and wraps never contribute to `drop_cnt`.

## Test plan
- Hold `reset`=0 for 2 edges with random counts. Required: all outputs 0 and `evt_valid`=0; these hold for 5 cycles after release with counts static.
- Enable, step all counters 0→20 by +1 with `evt_ready`=1. Required: no events, `err_any`=0, `wrap_cnt*`=0.
- Drive `count0` 254→255→0. Required: `wrap_cnt0`=1. With the macro, `evt_data`={0,1,0x00} and `evt_valid` is asserted 2 edges after the 0 sample. Without the macro, no event.
- Drive `count1` 5→9. Required: `err_any`=1 and event {1,0,0x09}. In the same cycle, `count2` 3→7 produces {2,0,0x07} exactly one cycle later (round robin).
- Hold `evt_ready`=0 and inject 10 step errors spread over the three channels. Required: FIFO holds 4 entries, pending holds 3, `drop_cnt`=3, and the order is preserved on drain.
- Drop `enable` for 1 cycle and jump `count2` 10→50. Required: no error event on re-enable; the next +1 step is OK.
